// File: rtl/memory_rw_arbiter.sv
// Round-robin arbiter that puts one writer and one reader onto a single memory port.
// Memory strobes are registered, and read data comes back in order through a fixed-latency tag pipeline.
module memory_rw_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_in
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("memory_rw_arbiter: READ_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

    grant_e              last_q, last_d;
    logic                mem_we_q, mem_re_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_dout_q;
    logic [READ_LATENCY:0] tag_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // A grant is only raised while its request is high, so a grant implies a transfer.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        last_d = last_q;
        if (!rst) begin
            if (wr_req && rd_req) begin
                if (last_q == GRANT_RD) wr_gnt = 1'b1;
                else                    rd_gnt = 1'b1;
            end else begin
                wr_gnt = wr_req;
                rd_gnt = rd_req;
            end
            if (wr_gnt)      last_d = GRANT_WR;
            else if (rd_gnt) last_d = GRANT_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= GRANT_RD;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            tag_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            last_q   <= last_d;
            mem_we_q <= wr_gnt;
            mem_re_q <= rd_gnt;
            if (wr_gnt) begin
                mem_addr_q <= wr_addr;
                mem_dout_q <= wr_data;
            end else if (rd_gnt) begin
                mem_addr_q <= rd_addr;
            end
            // tag_q[k] is high in the k-th cycle after the read strobe.
            tag_q      <= {tag_q[READ_LATENCY-1:0], rd_gnt};
            rd_valid_q <= tag_q[READ_LATENCY];
            if (tag_q[READ_LATENCY]) rd_data_q <= mem_data_in;
        end
    end

    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_address      = mem_addr_q;
    assign mem_data_out     = mem_dout_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;

endmodule

// File: tb/tb_memory_rw_arbiter.sv
// Random plus scripted stimulus into two arbiters (read latency 1 and 3).
// The results are compared against a cycle-level reference model of the grant, issue and return rules.
module tb_memory_rw_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NCYC = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    logic [1:0]         wr_gnt, rd_gnt, rd_valid, mwe, mre;
    logic [1:0][AW-1:0] maddr;
    logic [1:0][DW-1:0] rdata, mdout, mdin;

    memory_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt[0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt[0]),
        .rd_data(rdata[0]), .rd_valid(rd_valid[0]),
        .mem_address(maddr[0]), .mem_data_out(mdout[0]),
        .mem_write_enable(mwe[0]), .mem_read_enable(mre[0]), .mem_data_in(mdin[0])
    );

    memory_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt[1]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt[1]),
        .rd_data(rdata[1]), .rd_valid(rd_valid[1]),
        .mem_address(maddr[1]), .mem_data_out(mdout[1]),
        .mem_write_enable(mwe[1]), .mem_read_enable(mre[1]), .mem_data_in(mdin[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Memory model history: read strobe and address seen on each port per cycle.
    logic          re_h [2][NCYC];
    logic [AW-1:0] ad_h [2][NCYC];

    // Reference model state.
    logic          last_w;
    logic          wr_acc, rd_acc;
    logic [1:0]    ex_we, ex_re;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_dout;
    logic [1:0][DW-1:0] ex_rd;
    int            qa[$];
    logic [DW-1:0] qd[$];
    int            hd[2];

    initial begin
        logic          eg_w, eg_r, nw, nr;
        logic [AW-1:0] na, nra;
        logic [DW-1:0] nd;
        int            dens_w, dens_r;
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; mdin = '0;
        last_w = 1'b0; wr_acc = 1'b0; rd_acc = 1'b0;
        ex_we = '0; ex_re = '0; ex_addr = '0; ex_dout = '0; ex_rd = '0;
        hd[0] = 0; hd[1] = 0;
        @(posedge clk); #1;
        for (int c = 0; c < NCYC; c++) begin
            rst = (c < 2) || (c == 38) || (c >= 45 && $urandom_range(0, 59) == 0);
            dens_w = 20 + 25 * ((c / 100) % 4);
            dens_r = 20 + 25 * (((c / 100) + 2) % 4);
            if (!wr_req || wr_acc) begin
                nw = 1'b0; na = $urandom; nd = $urandom;
                if (c >= 45)       nw = ($urandom_range(0, 99) < dens_w);
                else if (c == 12) begin nw = 1'b1; na = 32'h10; nd = 32'hDEADBEEF; end
                else if (c == 20)  nw = 1'b1;
                wr_req = nw; wr_addr = na; wr_data = nd;
            end
            if (!rd_req || rd_acc) begin
                nr = 1'b0; nra = $urandom;
                if (c >= 45)                 nr = ($urandom_range(0, 99) < dens_r);
                else if (c == 16)            begin nr = 1'b1; nra = 32'h20; end
                else if (c == 20)            nr = 1'b1;
                else if (c >= 30 && c <= 32) begin nr = 1'b1; nra = c - 29; end
                else if (c >= 36 && c <= 38) begin nr = 1'b1; nra = 32'h100 + c; end
                rd_req = nr; rd_addr = nra;
            end

            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                re_h[i][c] = (c >= 1) ? mre[i] : 1'b0;
                ad_h[i][c] = maddr[i];
                if (c >= lat(i) && re_h[i][c-lat(i)] === 1'b1) mdin[i] = pat(ad_h[i][c-lat(i)]);
                else                                            mdin[i] = $urandom;
            end

            // Rule: when both ask, the side that did not win last time goes first.
            eg_w = 1'b0; eg_r = 1'b0;
            if (!rst) begin
                if (wr_req && rd_req) begin
                    eg_w = !last_w;
                    eg_r = last_w;
                end else begin
                    eg_w = wr_req;
                    eg_r = rd_req;
                end
            end

            for (int i = 0; i < 2; i++) begin
                chk($sformatf("wr_gnt L%0d c%0d", lat(i), c), 64'(wr_gnt[i]), 64'(eg_w));
                chk($sformatf("rd_gnt L%0d c%0d", lat(i), c), 64'(rd_gnt[i]), 64'(eg_r));
                if (c >= 1) begin
                    chk($sformatf("mem_we L%0d c%0d", lat(i), c), 64'(mwe[i]), 64'(ex_we[i]));
                    chk($sformatf("mem_re L%0d c%0d", lat(i), c), 64'(mre[i]), 64'(ex_re[i]));
                    chk($sformatf("mem_addr L%0d c%0d", lat(i), c), 64'(maddr[i]), 64'(ex_addr));
                    chk($sformatf("mem_dout L%0d c%0d", lat(i), c), 64'(mdout[i]), 64'(ex_dout));
                    if (hd[i] < qa.size() && qa[hd[i]] + lat(i) + 2 == c) begin
                        ex_rd[i] = qd[hd[i]];
                        hd[i]++;
                        chk($sformatf("rd_valid L%0d c%0d", lat(i), c), 64'(rd_valid[i]), 64'd1);
                    end else begin
                        chk($sformatf("rd_valid L%0d c%0d", lat(i), c), 64'(rd_valid[i]), 64'd0);
                    end
                    chk($sformatf("rd_data L%0d c%0d", lat(i), c), 64'(rdata[i]), 64'(ex_rd[i]));
                end
            end

            if (rst) begin
                last_w = 1'b0; ex_we = '0; ex_re = '0; ex_addr = '0; ex_dout = '0; ex_rd = '0;
                hd[0] = qa.size(); hd[1] = qa.size();
            end else begin
                ex_we = {2{eg_w}};
                ex_re = {2{eg_r}};
                if (eg_w) begin
                    ex_addr = wr_addr; ex_dout = wr_data; last_w = 1'b1;
                end else if (eg_r) begin
                    ex_addr = rd_addr; last_w = 1'b0;
                    qa.push_back(c);
                    qd.push_back(pat(rd_addr));
                end
            end
            wr_acc = eg_w;
            rd_acc = eg_r;

            @(posedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
